// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state encoding, default line rates and the
// bit-period divider computation. The PARITY state exists only when
// UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int DEF_CLK_HZ = 25_000_000;
  localparam int DEF_BAUD   = 115_200;

  // state      | meaning
  // ST_IDLE    | line high, ready for a byte
  // ST_START   | start bit (0)
  // ST_DATA    | eight data bits, LSB first
  // ST_PARITY  | even parity bit (optional build)
  // ST_STOP    | stop bit (1)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Clock cycles per line bit, truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer. Emits a one-cycle tick every DIV cycles;
// i_restart realigns the period so the first tick lands DIV cycles later.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_gen: DIV must be at least 2");
  end

  assign w_tc   = (r_cnt == '0);
  assign o_tick = w_tc;

  // Down-counter: reload on restart or terminal count, otherwise decrement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || w_tc) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with valid/ready intake.
// Frame is 8N1 by default; defining UART_TX_PARITY_EN inserts an even
// parity bit between the data bits and the stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  logic       clk_25,
  input  logic       sys_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  state_t     r_state;
  logic [7:0] r_data;
  logic [2:0] r_bit_idx;
  logic       r_tx;
  logic       r_ready;
  logic       r_busy;

  logic       w_tick;
  logic       w_accept;
  logic [2:0] w_next_idx;

  assign w_accept   = (r_state == ST_IDLE) && r_ready && tx_valid;
  assign w_next_idx = r_bit_idx + 3'd1;

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .i_clk    (clk_25),
    .i_rst    (sys_reset),
    .i_restart(w_accept),
    .o_tick   (w_tick)
  );

  // Frame sequencer; every output is registered so tx never glitches.
  always_ff @(posedge clk_25) begin
    if (sys_reset) begin
      r_state   <= ST_IDLE;
      r_data    <= 8'h00;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_data    <= tx_data;
            r_bit_idx <= 3'd0;
            r_state   <= ST_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_data[0];
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              r_state   <= ST_PARITY;
              r_tx      <= ^r_data;
`else
              r_state   <= ST_STOP;
              r_tx      <= 1'b1;
`endif
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_data[w_next_idx];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLK_HZ=16, BAUD=1 (16 cycles
// per bit). A frame-level model predicts tx/tx_busy/tx_ready every cycle; a
// line receiver decodes frames from tx; directed scenarios pin literal values.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * DIV;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  uart_tx #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .clk_25   (clk),
    .sys_reset(sys_reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
  endtask

  // ---------------- frame-level reference model ----------------
  logic       m_started  = 1'b0;
  logic       m_tx       = 1'b1;
  logic       m_busy     = 1'b0;
  logic       m_ready    = 1'b0;
  logic       m_in_frame = 1'b0;
  int         m_k        = 0;
  int         n_acc      = 0;
  int         acc_cyc    = 0;
  logic       m_bits[NB];
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    m_started = 1'b1;
    if (sys_reset) begin
      if (m_in_frame) void'(exp_q.pop_back());
      m_in_frame = 1'b0;
      m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
    end else if (m_in_frame) begin
      m_k++;
      if (m_k >= FRAME_CYC) begin
        m_in_frame = 1'b0;
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end else begin
        m_tx = m_bits[m_k / DIV];
      end
    end else if (tx_valid && m_ready) begin
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[i+1] = tx_data[i];
`ifdef UART_TX_PARITY_EN
      m_bits[9] = ^tx_data;
`endif
      m_bits[NB-1] = 1'b1;
      exp_q.push_back(tx_data);
      m_in_frame = 1'b1; m_k = 0;
      m_tx = 1'b0; m_busy = 1'b1; m_ready = 1'b0;
      n_acc++; acc_cyc = cyc;
    end else begin
      m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("tx", tx, m_tx);
      chk("busy", tx_busy, m_busy);
      chk("ready", tx_ready, m_ready);
    end
  end

  // ---------------- line receiver ----------------
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_idx = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (sys_reset !== 1'b0) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1; rx_cnt = 0; rx_byte = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        rx_idx = rx_cnt / DIV;
        if (rx_idx == 0) chk("rx_start", tx, 1'b0);
        else if (rx_idx <= 8) rx_byte = {tx, rx_byte[7:1]};
`ifdef UART_TX_PARITY_EN
        if (rx_idx == 9) chk("rx_parity", tx, ^rx_byte);
`endif
        if (rx_idx == NB - 1) begin
          chk("rx_stop", tx, 1'b1);
          if (exp_q.size() > 0) chk("rx_byte", rx_byte, exp_q.pop_front());
          else chk("rx_pending", exp_q.size(), 1);
          rx_log.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(output int a);
    int n0;
    int lim;
    n0 = n_acc;
    lim = cyc + 40 * DIV;
    while (n_acc == n0 && cyc < lim) @(negedge clk);
    chk("accept_seen", n_acc - n0, 1);
    a = acc_cyc;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, hi, zeros, rdy_hi, nrx0, nacc0;
    logic [NB-1:0] pat;
    logic [7:0] b;

    // Reset held for 20 cycles from start.
    sys_reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      at_cyc(i);
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
    end
    sys_reset = 1'b0;
    at_cyc(21);
    chk("ready_after_rst", tx_ready, 1'b1);

    // Single literal frame.
`ifdef UART_TX_PARITY_EN
    b = 8'h07; pat = 11'b11000001110;
`else
    b = 8'h55; pat = 10'b1010101010;
`endif
    at_cyc(cyc + 3);
    nrx0 = rx_log.size();
    tx_data = b; tx_valid = 1'b1;
    wait_accept(a);
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      at_cyc(a + k);
      chk("frame_bit", tx, pat[k / DIV]);
    end
    at_cyc(a + FRAME_CYC - 1);
    chk("ready_early", tx_ready, 1'b0);
    at_cyc(a + FRAME_CYC);
    chk("ready_return", tx_ready, 1'b1);
    chk("lit_rx_count", rx_log.size(), nrx0 + 1);
    if (rx_log.size() > 0) chk("lit_rx_byte", rx_log[$], b);

    // Back-to-back with tx_valid held.
    at_cyc(cyc + 7);
    nrx0 = rx_log.size();
    nacc0 = n_acc;
    tx_data = 8'hA5; tx_valid = 1'b1;
    wait_accept(a);
    tx_data = 8'h3C;
    at_cyc(a + (NB - 1) * DIV);
    hi = 0;
    while (tx === 1'b1 && hi < 3 * DIV) begin
      hi++;
      at_cyc(cyc + 1);
    end
    chk("b2b_gap", hi, DIV + 1);
    if (n_acc == nacc0 + 1) wait_accept(a2);
    else a2 = acc_cyc;
    tx_valid = 1'b0;
    chk("b2b_spacing", a2 - a, FRAME_CYC + 1);
    at_cyc(a2 + FRAME_CYC + 2);
    chk("b2b_rx_count", rx_log.size(), nrx0 + 2);
    if (rx_log.size() >= nrx0 + 2) begin
      chk("b2b_rx_first", rx_log[nrx0], 8'hA5);
      chk("b2b_rx_second", rx_log[nrx0+1], 8'h3C);
    end

    // Reset pulse mid-frame aborts the frame.
    at_cyc(cyc + 5);
    nrx0 = rx_log.size();
    tx_data = 8'hFF; tx_valid = 1'b1;
    wait_accept(a);
    tx_valid = 1'b0;
    at_cyc(a + 49);
    sys_reset = 1'b1;
    at_cyc(a + 50);
    sys_reset = 1'b0;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_ready_low", tx_ready, 1'b0);
    at_cyc(a + 51);
    chk("abort_ready_back", tx_ready, 1'b1);
    zeros = 0;
    for (int k = 0; k < 200; k++) begin
      at_cyc(cyc + 1);
      if (tx !== 1'b1) zeros++;
    end
    chk("abort_no_resume", zeros, 0);
    chk("abort_no_rx", rx_log.size(), nrx0);

    // tx_data/tx_valid churn during a frame.
    nrx0 = rx_log.size();
    tx_data = 8'h81; tx_valid = 1'b1;
    wait_accept(a);
    rdy_hi = 0;
    for (int k = 1; k < FRAME_CYC - 20; k++) begin
      at_cyc(a + k);
      if (tx_ready !== 1'b0) rdy_hi++;
      tx_data = 8'($urandom);
      tx_valid = 1'($urandom_range(0, 1));
    end
    tx_valid = 1'b0;
    chk("churn_no_ready", rdy_hi, 0);
    at_cyc(a + FRAME_CYC + 1);
    chk("churn_rx_count", rx_log.size(), nrx0 + 1);
    if (rx_log.size() > nrx0) chk("churn_rx_byte", rx_log[nrx0], 8'h81);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      at_cyc(cyc + $urandom_range(0, 20));
      tx_data = 8'($urandom); tx_valid = 1'b1;
      wait_accept(a);
      for (int k = 1; k <= $urandom_range(0, FRAME_CYC - 2); k++) begin
        at_cyc(a + k);
        tx_data = 8'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
      end
      tx_valid = 1'b0;
    end
    at_cyc(cyc + FRAME_CYC + 20);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 clk_25  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 sys_reset  input  1  reset, synchronous, active-high; driven by the system reset pulse source.
REQ-005 tx_data  input  8  byte to transmit, sampled only at acceptance.
REQ-006 tx_valid  input  1  producer offers tx_data.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 tx_busy  output  1  a frame is in progress.
REQ-009 tx  output  1  serial line, idle high.

Function
REQ-010 DIV SHALL equal CLK_HZ/BAUD, truncated to an integer (217 at the defaults); DIV < 2 SHALL be an elaboration error.
REQ-011 Acceptance SHALL occur on a rising edge where tx_valid and tx_ready are both 1; tx_data SHALL be latched on that edge.
REQ-012 tx_ready SHALL be 1 only in IDLE while sys_reset is 0, and SHALL NOT depend combinationally on tx_valid.
REQ-013 FSM states:
- IDLE: on acceptance, go to START.
- START: go to DATA.
- DATA: after 8 bits, go to PARITY (if enabled) or STOP.
- PARITY: go to STOP.
- STOP: go to IDLE.
REQ-014 Each non-IDLE state SHALL last exactly DIV cycles, counted by a bit-period counter that is cleared at acceptance.
REQ-015 tx SHALL be registered; starting in the cycle after acceptance, it SHALL output the start bit (0), then data bits LSB first, then stop (1).
REQ-016 tx SHALL be 1 in IDLE and in STOP.
REQ-017 tx_busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-018 tx_ready SHALL return to 1 exactly 10*DIV cycles after acceptance, or 11*DIV cycles with parity.
REQ-019 Back-to-back: with tx_valid held at 1, the next byte SHALL be accepted in the first cycle tx_ready is 1; minimum line-high time between frames SHALL be DIV+1 cycles.
REQ-020 Changes on tx_data or tx_valid during a frame SHALL have no effect on that frame.
REQ-021 The counter and bit index SHALL wrap only through state transitions, never by overflow.

Reset
REQ-022 While sys_reset=1: state=IDLE, tx=1, tx_ready=0, tx_busy=0, counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 on the next edge, and the frame SHALL NOT resume.
REQ-024 tx_ready SHALL rise on the first edge after sys_reset falls.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be present and transmit even parity (XOR of the 8 data bits).
REQ-026 With UART_TX_PARITY_EN undefined, the PARITY state SHALL be absent, frames SHALL be 8N1, and the FSM SHALL go from DATA directly to STOP.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings, the default CLK_HZ/BAUD constants, and the DIV computation.
REQ-028 One sub-module, uart_baud_gen, SHALL produce a one-cycle bit-period tick every DIV cycles, with a synchronous restart input driven at acceptance.

Verification (bench uses CLK_HZ=16, BAUD=1, so DIV=16)
REQ-029 Send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each value held 16 cycles; tx_ready high again at acceptance+160.
REQ-030 With UART_TX_PARITY_EN, send 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop; tx_ready high at acceptance+176.
REQ-031 tx_valid held with 0xA5 then 0x3C -> two complete frames; line high exactly 17 cycles between them; second frame decodes as 0x3C.
REQ-032 sys_reset pulsed for 1 cycle at acceptance+50 of 0xFF -> tx=1 next edge; tx_busy=0; tx_ready=1 one edge after reset falls; no further 0 bits.
REQ-033 Toggle tx_data mid-frame of 0x81 -> received byte is 0x81; no extra acceptance while tx_busy=1.
REQ-034 Hold sys_reset for 20 cycles from start -> tx=1, tx_ready=0, tx_busy=0 throughout.
